output_drain_ctrl: RTL and testbench

- Sequences the per-column output shift registers at the bottom of the systolic array for one tile.
- Times each column's load window to the array's diagonal skew, then drains all columns in lock-step into the output buffer, one row per accepted write.
- Generates output-buffer addresses and clears the shift registers between tiles.
- Sits between the top-level tile scheduler (start/done) and the array's output-buffer write port.

---
 rtl/output_drain_ctrl_pkg.sv | 29 ++
 rtl/output_drain_ctrl_skew_window_gen.sv | 20 ++
 rtl/output_drain_ctrl.sv | 134 +++++++++++++
 tb/tb_output_drain_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/output_drain_ctrl_pkg.sv
// Shared defaults, state encoding and counter sizing for the systolic-array output drain controller.
package output_drain_ctrl_pkg;

    localparam int DEF_ARRAY_HEIGHT = 8;
    localparam int DEF_ARRAY_WIDTH  = 8;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_ADDR_W       = 10;
    localparam int DEF_K_W          = 16;
    localparam int DEF_PIPE_LAT     = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        LOAD  = 3'd2,
        DRAIN = 3'd3,
        CLEAR = 3'd4
    } state_t;

    // One counter serves both the WAIT countdown (up to k_len + PIPE_LAT - 1)
    // and the LOAD window sweep (up to H + W - 2), so size it for the larger.
    function automatic int cnt_width(input int h, input int w, input int k_w);
        int win;
        int kw;
        win = $clog2(h + w);
        kw  = k_w + 2;
        return (win > kw) ? win : kw;
    endfunction

endpackage

// File: rtl/output_drain_ctrl_skew_window_gen.sv
// Per-column load window: column c loads while cnt is in [c, c + HEIGHT - 1].
module output_drain_ctrl_skew_window_gen #(
    parameter int HEIGHT = 8,
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 18
) (
    input  logic             active,
    input  logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] load_en
);

    // cnt - c wraps to a huge value when cnt < c, so a single unsigned
    // compare against HEIGHT covers both ends of the window.
    for (genvar c = 0; c < WIDTH; c++) begin : g_col
        logic [CNT_W:0] offs;
        assign offs       = {1'b0, cnt} - (CNT_W + 1)'(c);
        assign load_en[c] = active && (offs < (CNT_W + 1)'(HEIGHT));
    end

endmodule

// File: rtl/output_drain_ctrl.sv
// Sequences skewed shift-register loads, lock-step drain into the output buffer, and clear per tile.
module output_drain_ctrl
    import output_drain_ctrl_pkg::*;
#(
    parameter int ARRAY_HEIGHT = DEF_ARRAY_HEIGHT,
    parameter int ARRAY_WIDTH  = DEF_ARRAY_WIDTH,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int K_W          = DEF_K_W,
    parameter int PIPE_LAT     = DEF_PIPE_LAT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [K_W-1:0]                k_len,
    input  logic [ADDR_W-1:0]             base_addr,
    output logic                          busy,
    output logic                          done,
    output logic [ARRAY_WIDTH-1:0]        load_en,
    output logic [ARRAY_WIDTH-1:0]        out_en,
    output logic                          sr_clr,
    input  logic [ARRAY_WIDTH*DATA_W-1:0] col_data,
    input  logic                          wr_ready,
    output logic                          wr_en,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [ARRAY_WIDTH*DATA_W-1:0] wr_data
);

    localparam int CNT_W = cnt_width(ARRAY_HEIGHT, ARRAY_WIDTH, K_W);
    localparam int ROW_W = $clog2(ARRAY_HEIGHT) + 1;
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(ARRAY_HEIGHT + ARRAY_WIDTH - 2);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ARRAY_HEIGHT - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ROW_W-1:0]  row, row_nxt;
    logic [ADDR_W-1:0] base_q, addr_q, drain_addr;
    logic [CNT_W-1:0]  wait_init;
    logic              wait_skip;
    logic              load_active;

    assign wait_init  = CNT_W'(k_len) + CNT_W'(PIPE_LAT) - CNT_W'(1);
    assign wait_skip  = (k_len == '0) && (PIPE_LAT == 0);
    assign drain_addr = base_q + ADDR_W'(row);
    assign busy       = (state != IDLE);
    assign wr_data    = col_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            row    <= '0;
            base_q <= '0;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            row   <= row_nxt;
            if (state == IDLE && start)
                base_q <= base_addr;
            // Outside DRAIN the address port shows the last address driven.
            if (state == DRAIN)
                addr_q <= drain_addr;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        row_nxt     = row;
        done        = 1'b0;
        sr_clr      = 1'b0;
        wr_en       = 1'b0;
        out_en      = '0;
        wr_addr     = addr_q;
        load_active = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    row_nxt   = '0;
                    cnt_nxt   = wait_skip ? '0 : wait_init;
                    state_nxt = wait_skip ? LOAD : WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0)
                    state_nxt = LOAD;
                else
                    cnt_nxt = cnt - CNT_W'(1);
            end
            LOAD: begin
                load_active = 1'b1;
                if (cnt == LOAD_LAST) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                    row_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                // A stalled write must not shift, or a row would be lost.
                wr_en   = wr_ready;
                out_en  = {ARRAY_WIDTH{wr_ready}};
                wr_addr = drain_addr;
                if (wr_ready) begin
                    if (row == ROW_LAST)
                        state_nxt = CLEAR;
                    else
                        row_nxt = row + ROW_W'(1);
                end
            end
            CLEAR: begin
                sr_clr    = 1'b1;
                done      = 1'b1;
                cnt_nxt   = '0;
                row_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    output_drain_ctrl_skew_window_gen #(
        .HEIGHT (ARRAY_HEIGHT),
        .WIDTH  (ARRAY_WIDTH),
        .CNT_W  (CNT_W)
    ) u_skew (
        .active  (load_active),
        .cnt     (cnt),
        .load_en (load_en)
    );

endmodule

// File: tb/tb_output_drain_ctrl.sv
// Directed bench for output_drain_ctrl at H=W=4, PIPE_LAT=2.
module tb_output_drain_ctrl;

    localparam int H  = 4;
    localparam int W  = 4;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int KW = 16;
    localparam int PL = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [KW-1:0]     k_len;
    logic [AW-1:0]     base_addr;
    logic              busy, done, sr_clr, wr_en, wr_ready;
    logic [W-1:0]      load_en, out_en;
    logic [W*DW-1:0]   col_data, wr_data;
    logic [AW-1:0]     wr_addr;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] exp_load [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

    always #5 clk = ~clk;

    output_drain_ctrl #(
        .ARRAY_HEIGHT (H),
        .ARRAY_WIDTH  (W),
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .K_W          (KW),
        .PIPE_LAT     (PL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .load_en   (load_en),
        .out_en    (out_en),
        .sr_clr    (sr_clr),
        .col_data  (col_data),
        .wr_ready  (wr_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, then sample combinational outputs 1 ns later.
    task automatic step(input logic st, input logic rdy);
        @(negedge clk);
        start    = st;
        wr_ready = rdy;
        col_data = {$urandom, $urandom, $urandom, $urandom};
        #1;
    endtask

    task automatic tile(input logic [KW-1:0] k, input logic [AW-1:0] base,
                        input logic [15:0] pat, input int npat,
                        input bit poke, input int abort_at);
        int            row;
        int            i;
        logic          rdy;
        logic [AW-1:0] ea;
        @(negedge clk);
        start     = 1'b1;
        k_len     = k;
        base_addr = base;
        wr_ready  = 1'b1;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        for (int j = 0; j < int'(k) + PL; j++) begin
            step(1'b0, 1'b1);
            chk("wait_busy", busy, 1);
            chk("wait_load_en", load_en, 0);
            chk("wait_wr_en", wr_en, 0);
        end
        for (int j = 0; j < H + W - 1; j++) begin
            step(poke && j == 2, 1'b1);
            chk("load_en", load_en, exp_load[j]);
            chk("load_out_en", out_en, 0);
            chk("load_wr_en", wr_en, 0);
        end
        row = 0;
        i   = 0;
        while (row < H && i < 32) begin
            if (abort_at >= 0 && row == abort_at)
                return;
            rdy = (i < npat) ? pat[i] : 1'b1;
            step(1'b0, rdy);
            chk("drain_wr_en", wr_en, rdy);
            chk("drain_out_en", out_en, {4{rdy}});
            chk("drain_done", done, 0);
            if (rdy) begin
                ea = base + AW'(row);
                chk("drain_addr", wr_addr, ea);
                chk("drain_data", wr_data, col_data);
                row++;
            end
            i++;
        end
        step(poke, 1'b1);
        chk("clear_sr_clr", sr_clr, 1);
        chk("clear_done", done, 1);
        chk("clear_busy", busy, 1);
        chk("clear_wr_en", wr_en, 0);
        ea = base + AW'(H - 1);
        chk("clear_addr_hold", wr_addr, ea);
        start = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        k_len     = '0;
        base_addr = '0;
        wr_ready  = 1'b0;
        col_data  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_load_en", load_en, 0);
        chk("rst_out_en", out_en, 0);
        chk("rst_sr_clr", sr_clr, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        rst = 1'b0;

        // nominal tile
        tile(16'd3, 10'h010, 16'h0000, 0, 1'b0, -1);
        // backpressure: ready 1,0,0,1,1,0,1
        tile(16'd3, 10'h010, 16'b0101_1001, 7, 1'b0, -1);
        // zero reduction length: two WAIT cycles
        tile(16'd0, 10'h020, 16'h0000, 0, 1'b0, -1);
        // starts in LOAD and in the done cycle ignored; next-cycle start accepted
        tile(16'd3, 10'h040, 16'h0000, 0, 1'b1, -1);
        tile(16'd1, 10'h050, 16'h0000, 0, 1'b0, -1);

        // reset after two writes
        tile(16'd3, 10'h060, 16'h0000, 0, 1'b0, 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_load_en", load_en, 0);
        chk("abort_out_en", out_en, 0);
        chk("abort_sr_clr", sr_clr, 0);
        chk("abort_wr_en", wr_en, 0);
        chk("abort_wr_addr", wr_addr, 0);
        step(1'b0, 1'b1);
        chk("abort_no_done", done, 0);
        chk("abort_idle", busy, 0);
        tile(16'd2, 10'h070, 16'h0000, 0, 1'b0, -1);

        // address wrap
        tile(16'd3, 10'h3FE, 16'h0000, 0, 1'b0, -1);
        step(1'b0, 1'b1);
        chk("final_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
